// File: rtl/leos_gpio_pkg.sv
// Shared definitions for the leos_gpio block: register indices and
// parameter bounds.
package leos_gpio_pkg;

   typedef enum logic [2:0] {
      REG_DATA_OUT = 3'd0,
      REG_OE       = 3'd1,
      REG_DATA_IN  = 3'd2,
      REG_SET_OUT  = 3'd3,
      REG_CLR_OUT  = 3'd4,
      REG_RISE_EN  = 3'd5,
      REG_FALL_EN  = 3'd6,
      REG_IRQ_STAT = 3'd7
   } reg_idx_e;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int GPIO_MAX_WIDTH  = 32;
   // Warm-up counter must hold SYNC_STAGES_MAX+1.
   localparam int WARM_W          = 3;

endpackage

// File: rtl/leos_gpio_sync.sv
// Pad input synchronizer with one extra delayed copy; produces per-bit
// rising/falling edge strobes from the synchronized value.
module gpio_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             hclk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] sync_val,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
   logic [WIDTH-1:0]                  dly;

   // Shift pads through the synchronizer; dly trails the output by one cycle.
   always_ff @(posedge hclk) begin
      if (!resetn) begin
         chain <= '0;
         dly   <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pins};
         dly   <= chain[SYNC_STAGES-1];
      end
   end

   assign sync_val = chain[SYNC_STAGES-1];
   assign rise     = sync_val & ~dly;
   assign fall     = ~sync_val & dly;

endmodule

// File: rtl/leos_gpio.sv
// GPIO block: register file on a single-cycle request/ack bus, pad output
// and enable registers, synchronized inputs with edge-triggered W1C status.
module leos_gpio
   import leos_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             PORESETn,
   input  logic             REQ,
   input  logic             WE,
   input  logic [2:0]       ADDR,
   input  logic [WIDTH-1:0] WDATA,
   output logic [WIDTH-1:0] RDATA,
   output logic             ACK,
   input  logic [WIDTH-1:0] GPIO_I,
   output logic [WIDTH-1:0] GPIO_O,
   output logic [WIDTH-1:0] GPIO_OE,
   output logic             IRQ
);

   if (WIDTH < 1 || WIDTH > GPIO_MAX_WIDTH) begin : g_bad_width
      $error("leos_gpio: WIDTH must be in 1..32");
   end
   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("leos_gpio: SYNC_STAGES must be in 2..4");
   end

   localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] dout_q, oe_q, ren_q, fen_q, stat_q, rdata_q;
   logic [WIDTH-1:0] dout_n, oe_n, ren_n, fen_n, stat_n;
   logic [WIDTH-1:0] w1c, edges, rd_mux;
   logic [WIDTH-1:0] sync_val, rise, fall;
   logic [WARM_W-1:0] warm_q;
   logic             ack_q, irq_q, edge_en;

   gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .hclk     (CLK),
      .resetn   (PORESETn),
      .pins     (GPIO_I),
      .sync_val (sync_val),
      .rise     (rise),
      .fall     (fall)
   );

   // Edges seen while the synchronizer is still filling after reset are
   // artefacts of the flush, not pin activity.
   assign edge_en = (warm_q == '0);

   // Read mux: register contents as they stand in the request cycle.
   always_comb begin
      rd_mux = '0;
      case (reg_idx_e'(ADDR))
         REG_DATA_OUT: rd_mux = dout_q;
         REG_OE:       rd_mux = oe_q;
         REG_DATA_IN:  rd_mux = sync_val;
         REG_RISE_EN:  rd_mux = ren_q;
         REG_FALL_EN:  rd_mux = fen_q;
         REG_IRQ_STAT: rd_mux = stat_q;
         default:      rd_mux = '0;
      endcase
   end

   // Write decode and status update; a new edge beats a same-cycle W1C.
   always_comb begin
      dout_n = dout_q;
      oe_n   = oe_q;
      ren_n  = ren_q;
      fen_n  = fen_q;
      w1c    = '0;
      if (REQ && WE) begin
         case (reg_idx_e'(ADDR))
            REG_DATA_OUT: dout_n = WDATA;
            REG_OE:       oe_n   = WDATA;
            REG_SET_OUT:  dout_n = dout_q | WDATA;
            REG_CLR_OUT:  dout_n = dout_q & ~WDATA;
            REG_RISE_EN:  ren_n  = WDATA;
            REG_FALL_EN:  fen_n  = WDATA;
            REG_IRQ_STAT: w1c    = WDATA;
            default:      ;
         endcase
      end
      edges  = edge_en ? ((rise & ren_q) | (fall & fen_q)) : '0;
      stat_n = (stat_q & ~w1c) | edges;
   end

   // State registers, bus response and warm-up countdown.
   always_ff @(posedge CLK) begin
      if (!PORESETn) begin
         dout_q  <= '0;
         oe_q    <= '0;
         ren_q   <= '0;
         fen_q   <= '0;
         stat_q  <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
         warm_q  <= WARM_INIT;
      end else begin
         dout_q  <= dout_n;
         oe_q    <= oe_n;
         ren_q   <= ren_n;
         fen_q   <= fen_n;
         stat_q  <= stat_n;
         rdata_q <= (REQ && !WE) ? rd_mux : '0;
         ack_q   <= REQ;
         irq_q   <= |stat_q;
         if (!edge_en) warm_q <= warm_q - WARM_W'(1);
      end
   end

   assign RDATA   = rdata_q;
   assign ACK     = ack_q;
   assign GPIO_O  = dout_q;
   assign GPIO_OE = oe_q;
   assign IRQ     = irq_q;

endmodule

// File: tb/tb_leos_gpio.sv
// Scoreboard bench for leos_gpio: driver steps a pin-history reference
// model and queues expected bus responses; a monitor checks every cycle.
module tb_leos_gpio;

   localparam int W = 8;
   localparam int S = 2;

   logic         CLK = 1'b0;
   logic         PORESETn = 1'b0;
   logic         REQ = 1'b0, WE = 1'b0;
   logic [2:0]   ADDR = '0;
   logic [W-1:0] WDATA = '0, GPIO_I = '0;
   logic [W-1:0] RDATA, GPIO_O, GPIO_OE;
   logic         ACK, IRQ;

   always #5 CLK = ~CLK;

   leos_gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .PORESETn(PORESETn), .REQ(REQ), .WE(WE), .ADDR(ADDR),
      .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK), .GPIO_I(GPIO_I),
      .GPIO_O(GPIO_O), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
   );

   int tests = 0;
   int fails = 0;

   typedef struct { logic [W-1:0] rd; string tag; } exp_t;
   exp_t exp_q[$];

   // Reference model state
   logic [W-1:0] m_dout = '0, m_oe = '0, m_ren = '0, m_fen = '0, m_stat = '0;
   logic [W-1:0] hist[$];   // pin value captured at each past edge, newest last
   int           post = 0;  // edges since reset release
   logic [W-1:0] exp_o = '0, exp_oe = '0;
   logic         exp_irq = 1'b0;
   logic [W-1:0] cur_pin = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Advance the model by one clock edge with the given bus/pin inputs.
   task automatic model_edge(input bit rst_n, input bit req, input bit we,
                             input logic [2:0] a, input logic [W-1:0] d,
                             input logic [W-1:0] pin);
      logic [W-1:0] syn, dly, edg, rd, w1c;
      exp_t e;
      if (!rst_n) begin
         m_dout = '0; m_oe = '0; m_ren = '0; m_fen = '0; m_stat = '0;
         hist.delete();
         for (int i = 0; i <= S; i++) hist.push_back('0);
         post = 0;
         exp_irq = 1'b0;
      end else begin
         // DATA_IN is the pin as sampled S edges ago; its predecessor one earlier.
         syn = hist[hist.size() - S];
         dly = hist[hist.size() - S - 1];
         post++;
         exp_irq = |m_stat;
         rd = '0;
         if (req && !we) begin
            case (a)
               3'd0: rd = m_dout;
               3'd1: rd = m_oe;
               3'd2: rd = syn;
               3'd5: rd = m_ren;
               3'd6: rd = m_fen;
               3'd7: rd = m_stat;
               default: rd = '0;
            endcase
         end
         edg = (post >= S + 2) ? ((syn & ~dly & m_ren) | (~syn & dly & m_fen)) : '0;
         w1c = '0;
         if (req && we) begin
            case (a)
               3'd0: m_dout = d;
               3'd1: m_oe = d;
               3'd3: m_dout = m_dout | d;
               3'd4: m_dout = m_dout & ~d;
               3'd5: m_ren = d;
               3'd6: m_fen = d;
               3'd7: w1c = d;
               default: ;
            endcase
         end
         m_stat = (m_stat & ~w1c) | edg;
         if (req) begin
            e.rd = rd;
            e.tag = $sformatf("%s_a%0d", we ? "wr" : "rd", a);
            exp_q.push_back(e);
         end
      end
      hist.push_back(rst_n ? pin : '0);
      while (hist.size() > S + 2) void'(hist.pop_front());
      exp_o = m_dout;
      exp_oe = m_oe;
   endtask

   task automatic cyc(input bit rst_n, input bit req, input bit we,
                      input logic [2:0] a, input logic [W-1:0] d);
      @(negedge CLK);
      PORESETn = rst_n; REQ = req; WE = we; ADDR = a; WDATA = d; GPIO_I = cur_pin;
      model_edge(rst_n, req, we, a, d, cur_pin);
   endtask

   task automatic idle();                               cyc(1, 0, 0, 3'd0, '0); endtask
   task automatic wr(input logic [2:0] a, input logic [W-1:0] d); cyc(1, 1, 1, a, d);  endtask
   task automatic rd(input logic [2:0] a);              cyc(1, 1, 0, a, '0);    endtask

   // Sample just after the next rising edge for directed constant checks.
   task automatic after_edge();
      @(posedge CLK);
      #2;
   endtask

   // Monitor: pop one expectation per ACK; ACK must follow its REQ directly.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (ACK === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check({"rdata_", e.tag}, RDATA, e.rd);
         end
      end else begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({"missing_ack_", e.tag}, {31'd0, ACK}, 32'd1);
         end
         check("rdata_idle_zero", RDATA, '0);
      end
      check("gpio_o", GPIO_O, exp_o);
      check("gpio_oe", GPIO_OE, exp_oe);
      check("irq", {31'd0, IRQ}, {31'd0, exp_irq});
   end

   initial begin
      for (int i = 0; i <= S; i++) hist.push_back('0);

      // Pins high through reset: no spurious rising edge afterwards.
      cur_pin = 8'hFF;
      repeat (3) cyc(0, 0, 0, 3'd0, '0);
      repeat (10) idle();
      wr(3'd5, 8'hFF);
      repeat (3) idle();
      rd(3'd7);
      rd(3'd2);
      after_edge();
      check("warm_irq_low", {31'd0, IRQ}, 32'd0);

      // Same, but rise enables armed immediately after release.
      cyc(0, 0, 0, 3'd0, '0);
      wr(3'd5, 8'hFF);
      repeat (S + 3) idle();
      rd(3'd7);
      after_edge();
      check("warm_early_en_irq", {31'd0, IRQ}, 32'd0);
      check("warm_early_en_stat", RDATA, 8'h00);

      // Output register manipulation.
      wr(3'd0, 8'hA5);
      wr(3'd1, 8'h0F);
      wr(3'd3, 8'h10);
      wr(3'd4, 8'h01);
      rd(3'd3);
      after_edge();
      check("gpio_o_b4", GPIO_O, 8'hB4);
      check("gpio_oe_0f", GPIO_OE, 8'h0F);
      check("wo_read_zero", RDATA, 8'h00);
      wr(3'd2, 8'h55);   // DATA_IN is read-only
      rd(3'd2);

      // Falling edge on pin 2 raises status, then IRQ; W1C clears it.
      wr(3'd6, 8'h04);
      cur_pin = 8'hFB;
      repeat (S + 2) idle();
      rd(3'd7);
      after_edge();
      check("fall_stat_04", RDATA, 8'h04);
      check("fall_irq_high", {31'd0, IRQ}, 32'd1);
      wr(3'd7, 8'h04);
      idle();
      after_edge();
      check("w1c_irq_low", {31'd0, IRQ}, 32'd0);

      // W1C on bit 0 in the same cycle its rising edge lands: set wins.
      cur_pin = 8'hFA;
      repeat (4) idle();
      cur_pin = 8'hFB;
      idle();
      repeat (S - 1) idle();
      wr(3'd7, 8'h01);
      rd(3'd7);
      after_edge();
      check("set_beats_w1c", RDATA, 8'h01);

      // Back-to-back requests.
      wr(3'd0, 8'h3C);
      rd(3'd0);
      wr(3'd1, 8'h55);
      rd(3'd1);
      idle();

      // Reset mid-sequence with outputs enabled and IRQ pending.
      wr(3'd1, 8'hFF);
      cyc(0, 1, 1, 3'd0, 8'hAA);
      after_edge();
      check("rst_oe_zero", GPIO_OE, 8'h00);
      check("rst_ack_zero", {31'd0, ACK}, 32'd0);
      check("rst_irq_zero", {31'd0, IRQ}, 32'd0);
      idle();
      wr(3'd5, 8'hFF);
      cyc(0, 0, 0, 3'd0, '0);   // reset again during warm-up
      wr(3'd5, 8'hFF);
      wr(3'd6, 8'hFF);

      // Random traffic with pin activity and occasional resets.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) cur_pin ^= W'(1) << $urandom_range(0, W - 1);
         if ($urandom_range(0, 149) == 0)
            cyc(0, 1'($urandom_range(0, 1)), 1'b1, 3'd0, W'($urandom));
         else
            cyc(1, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), W'($urandom));
      end
      repeat (3) idle();
      after_edge();
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
